// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU front end.
// Opcode and controller state encodings.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    S_LOADA = 2'd0,
    S_LOADB = 2'd1,
    S_MUL   = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/seq_alu_ctrl_mult.sv
// Unsigned N-cycle shift-add multiplier, 2N-bit product.
// Used by seq_alu_ctrl only when SEQ_ALU_MUL_EN is defined.
module shift_add_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] prod
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]   r_a;
  logic [2*N-1:0] r_p;
  logic [CW-1:0]  r_cnt;
  logic [N:0]     w_sum;

  // High half accumulates; low half holds remaining multiplier bits.
  assign w_sum = {1'b0, r_p[2*N-1:N]}
               + (r_p[0] ? {1'b0, r_a} : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        r_a   <= A;
        r_p   <= {{N{1'b0}}, B};
        r_cnt <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        r_p   <= {w_sum, r_p[N-1:1]};
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(N - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign prod = r_p;

endmodule

// File: rtl/seq_alu_ctrl.sv
// Sequential ALU front end: A/op then B from one bus, STEP-driven.
// Define SEQ_ALU_MUL_EN to build the shift-add multiply (op 111).
module seq_alu_ctrl
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         CLK50M,
  input  logic         RST,
  input  logic         STEP,
  input  logic [N-1:0] INPUT,
  input  logic [2:0]   OPSEL,
  output logic [N-1:0] A_q,
  output logic [N-1:0] Result,
  output logic [N-1:0] ResultHi,
  output logic         V,
  output logic         C,
  output logic         Neg,
  output logic         Z,
  output logic         Busy,
  output logic         Done,
  output logic         Err
);

  seq_state_t   r_state;
  alu_op_t      r_op;
  logic         r_step_q;
  logic         w_step_edge;
  logic [N-1:0] w_res;
  logic         w_c;
  logic         w_v;
  logic [N:0]   w_sum;
  logic [N:0]   w_diff;

  assign w_step_edge = STEP & ~r_step_q;
  assign w_sum  = {1'b0, A_q} + {1'b0, INPUT};
  assign w_diff = {1'b0, A_q} - {1'b0, INPUT};

  // B is taken straight from the bus on the capture edge.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res = w_sum[N-1:0];
        w_c   = w_sum[N];
        w_v   = (A_q[N-1] == INPUT[N-1]) &&
                (w_sum[N-1] != A_q[N-1]);
      end
      OP_SUB: begin
        w_res = w_diff[N-1:0];
        w_c   = ~w_diff[N];
        w_v   = (A_q[N-1] != INPUT[N-1]) &&
                (w_diff[N-1] != A_q[N-1]);
      end
      OP_AND: w_res = A_q & INPUT;
      OP_OR:  w_res = A_q | INPUT;
      OP_XOR: w_res = A_q ^ INPUT;
      OP_SHL: begin
        w_res = {A_q[N-2:0], 1'b0};
        w_c   = A_q[N-1];
      end
      OP_SHR: begin
        w_res = {1'b0, A_q[N-1:1]};
        w_c   = A_q[0];
      end
      default: w_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  logic           w_start;
  logic           w_mbusy;
  logic           w_mdone;
  logic [2*N-1:0] w_prod;

  assign w_start = (r_state == S_LOADB) &&
                   w_step_edge && (r_op == OP_MUL);

  shift_add_mult #(.N(N)) u_mult (
    .clk   (CLK50M),
    .rst   (RST),
    .start (w_start),
    .A     (A_q),
    .B     (INPUT),
    .busy  (w_mbusy),
    .done  (w_mdone),
    .prod  (w_prod)
  );

  assign Busy = w_mbusy;
`else
  assign Busy = 1'b0;
`endif

  always_ff @(posedge CLK50M or posedge RST) begin
    if (RST) begin
      r_state  <= S_LOADA;
      r_op     <= OP_ADD;
      r_step_q <= 1'b0;
      A_q      <= '0;
      Result   <= '0;
      ResultHi <= '0;
      V        <= 1'b0;
      C        <= 1'b0;
      Neg      <= 1'b0;
      Z        <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      r_step_q <= STEP;
      case (r_state)
        S_LOADA: begin
          if (w_step_edge) begin
            A_q     <= INPUT;
            r_op    <= alu_op_t'(OPSEL);
            r_state <= S_LOADB;
          end
        end
        S_LOADB: begin
          if (w_step_edge) begin
            if (r_op == OP_MUL) begin
`ifdef SEQ_ALU_MUL_EN
              r_state <= S_MUL;
`else
              Err     <= 1'b1;
              Done    <= 1'b1;
              r_state <= S_DONE;
`endif
            end else begin
              Result   <= w_res;
              ResultHi <= '0;
              C        <= w_c;
              V        <= w_v;
              Neg      <= w_res[N-1];
              Z        <= (w_res == '0);
              Err      <= 1'b0;
              Done     <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
`ifdef SEQ_ALU_MUL_EN
        S_MUL: begin
          if (w_mdone) begin
            Result   <= w_prod[N-1:0];
            ResultHi <= w_prod[2*N-1:N];
            C        <= |w_prod[2*N-1:N];
            V        <= 1'b0;
            Neg      <= w_prod[2*N-1];
            Z        <= (w_prod == '0);
            Err      <= 1'b0;
            Done     <= 1'b1;
            r_state  <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (w_step_edge) begin
            A_q     <= INPUT;
            r_op    <= alu_op_t'(OPSEL);
            Done    <= 1'b0;
            r_state <= S_LOADB;
          end
        end
        default: r_state <= S_LOADA;
      endcase
    end
  end

endmodule
